// File: rtl/fa_bist_pkg.sv
// Shared state encoding, sweep constants and golden full-adder function for fa_bist.
// Imported by fa_golden and fa_bist.
package fa_bist_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam int         NUM_VEC  = 8;
  localparam logic [2:0] LAST_VEC = 3'd7;

  // Reference full adder: {a,b,c} in, {cout,sum} out.
  function automatic logic [1:0] fa_golden_fn(input logic [2:0] abc);
    logic x, y, z;
    {x, y, z} = abc;
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

endpackage

// File: rtl/fa_golden.sv
// Combinational reference adder giving the expected {cout,sum} for a stimulus vector.
// Zero latency; no flow control.
module fa_golden
  import fa_bist_pkg::*;
(
  input  logic [2:0] abc,
  output logic [1:0] exp_cs
);

  assign exp_cs = fa_golden_fn(abc);

endmodule

// File: rtl/fa_bist.sv
// Self-test controller sweeping a one-bit full adder through all eight input vectors.
// Optional FA_BIST_CONT_EN: back-to-back sweeps while start stays high, errors accumulate.
module fa_bist
  import fa_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       fail_vec,
  output logic             fail_seen
);

  localparam int         VW        = $clog2(NUM_VEC);
  localparam logic [3:0] SETTLE_LD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
  localparam state_t     VEC_ENTRY = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
`ifdef FA_BIST_CONT_EN
  // On a continuous restart the DONE cycle already presents vector 0,
  // so it stands in for that vector's first settle cycle.
  localparam logic [3:0] RESTART_LD    = (SETTLE_CYCLES > 1) ? 4'(SETTLE_CYCLES - 2) : 4'd0;
  localparam state_t     RESTART_ENTRY = (SETTLE_CYCLES > 1) ? SETTLE : CHECK;
`endif

  state_t           state_q, state_n;
  logic [VW-1:0]    vec_q, vec_n;
  logic [3:0]       cnt_q, cnt_n;
  logic [ERR_W-1:0] err_q, err_n;
  logic [2:0]       fvec_q, fvec_n;
  logic             fseen_q, fseen_n;
  logic             pass_q, pass_n;
  logic [1:0]       exp_cs;
  logic             mismatch;

  fa_golden u_golden (
    .abc    (vec_q),
    .exp_cs (exp_cs)
  );

  assign mismatch = (state_q == CHECK) && ({cout, sum} != exp_cs);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fvec_q  <= '0;
      fseen_q <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      vec_q   <= vec_n;
      cnt_q   <= cnt_n;
      err_q   <= err_n;
      fvec_q  <= fvec_n;
      fseen_q <= fseen_n;
      pass_q  <= pass_n;
    end
  end

  always_comb begin
    state_n = state_q;
    vec_n   = vec_q;
    cnt_n   = cnt_q;
    err_n   = err_q;
    fvec_n  = fvec_q;
    fseen_n = fseen_q;
    pass_n  = pass_q;
    unique case (state_q)
      IDLE: begin
        vec_n = '0;
        if (start) begin
          err_n   = '0;
          fvec_n  = '0;
          fseen_n = 1'b0;
          pass_n  = 1'b0;
          cnt_n   = SETTLE_LD;
          state_n = VEC_ENTRY;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) state_n = CHECK;
        else               cnt_n   = cnt_q - 4'd1;
      end
      CHECK: begin
        if (mismatch) begin
          if (err_q != {ERR_W{1'b1}}) err_n = err_q + 1'b1;
          if (!fseen_q) begin
            fvec_n  = vec_q;
            fseen_n = 1'b1;
          end
        end
        if (vec_q == LAST_VEC) begin
          // The final vector's result must be folded into pass here.
          pass_n  = !(fseen_q || mismatch);
          vec_n   = '0;
          state_n = DONE;
        end else begin
          vec_n   = vec_q + 1'b1;
          cnt_n   = SETTLE_LD;
          state_n = VEC_ENTRY;
        end
      end
      DONE: begin
        vec_n   = '0;
        state_n = IDLE;
`ifdef FA_BIST_CONT_EN
        if (start) begin
          cnt_n   = RESTART_LD;
          state_n = RESTART_ENTRY;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  assign {a, b, c}  = vec_q;
  assign busy       = (state_q == SETTLE) || (state_q == CHECK);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_vec   = fvec_q;
  assign fail_seen  = fseen_q;

endmodule

// File: tb/tb_fa_bist.sv
// Bench for fa_bist: three instances (settle 1/err 4, settle 1/err 2, settle 0/err 4) each
// driving its own behavioural adder with an injectable fault; per-cycle scoreboard on busy/done/abc.
module tb_fa_bist;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [2:0] abc;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       a_w[3], b_w[3], c_w[3], sum_w[3], cout_w[3];
  logic       busy_w[3], done_w[3], pass_w[3], fseen_w[3];
  logic [2:0] fvec_w[3];
  logic [3:0] err0, err2;
  logic [1:0] err1;
  int         fault[3];

  int   n_checks = 0;
  int   n_pass   = 0;
  cyc_t exp_q[$];
  cyc_t obs_q[$];
  logic res_done, res_pass, res_fseen;
  logic [2:0] res_fvec;
  int   res_err;

  always #5 clk = ~clk;

  // Adder under test: 1 = cout stuck at 0, 2 = sum inverted.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sum_w[i]  = a_w[i] ^ b_w[i] ^ c_w[i];
      cout_w[i] = (a_w[i] & b_w[i]) | (a_w[i] & c_w[i]) | (b_w[i] & c_w[i]);
      if (fault[i] == 1) cout_w[i] = 1'b0;
      if (fault[i] == 2) sum_w[i] = ~(a_w[i] ^ b_w[i] ^ c_w[i]);
    end
  end

  fa_bist #(.SETTLE_CYCLES(1), .ERR_W(4)) u0 (
    .clk(clk), .rst(rst), .start(start), .a(a_w[0]), .b(b_w[0]), .c(c_w[0]),
    .sum(sum_w[0]), .cout(cout_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_cnt(err0), .fail_vec(fvec_w[0]), .fail_seen(fseen_w[0]));

  fa_bist #(.SETTLE_CYCLES(1), .ERR_W(2)) u1 (
    .clk(clk), .rst(rst), .start(start), .a(a_w[1]), .b(b_w[1]), .c(c_w[1]),
    .sum(sum_w[1]), .cout(cout_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_cnt(err1), .fail_vec(fvec_w[1]), .fail_seen(fseen_w[1]));

  fa_bist #(.SETTLE_CYCLES(0), .ERR_W(4)) u2 (
    .clk(clk), .rst(rst), .start(start), .a(a_w[2]), .b(b_w[2]), .c(c_w[2]),
    .sum(sum_w[2]), .cout(cout_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .err_cnt(err2), .fail_vec(fvec_w[2]), .fail_seen(fseen_w[2]));

  function automatic int err_of(input int u);
    case (u)
      0:       return int'(err0);
      1:       return int'(err1);
      default: return int'(err2);
    endcase
  endfunction

  // Expected saturated error count and first failing vector for a fault mode.
  function automatic void model(input int f, input int errw, output int n, output logic [2:0] first);
    logic [2:0] x;
    logic gs, gc, ds, dc;
    int raw;
    raw = 0;
    first = 3'd0;
    for (int v = 0; v < 8; v++) begin
      x  = 3'(v);
      gs = ^x;
      gc = (x[2] & x[1]) | (x[2] & x[0]) | (x[1] & x[0]);
      ds = (f == 2) ? ~gs : gs;
      dc = (f == 1) ? 1'b0 : gc;
      if ({dc, ds} != {gc, gs}) begin
        if (raw == 0) first = x;
        raw++;
      end
    end
    n = (raw > (1 << errw) - 1) ? (1 << errw) - 1 : raw;
  endfunction

  // Expected per-cycle trace for a single sweep, followed by one idle cycle.
  task automatic push_sweep(input int s);
    cyc_t e;
    for (int k = 1; k <= 8 * (s + 1); k++) begin
      e.busy = 1'b1;
      e.done = 1'b0;
      e.abc  = 3'((k - 1) / (s + 1));
      exp_q.push_back(e);
    end
    e.busy = 1'b0; e.done = 1'b1; e.abc = 3'd0;
    exp_q.push_back(e);
    e.done = 1'b0;
    exp_q.push_back(e);
  endtask

  // Pulses start, records ncyc cycles of instance u, captures results at done.
  task automatic run_sweep(input int u, input int ncyc);
    cyc_t o;
    res_done = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      o.busy = busy_w[u];
      o.done = done_w[u];
      o.abc  = {a_w[u], b_w[u], c_w[u]};
      obs_q.push_back(o);
      if (done_w[u] && !res_done) begin
        res_done  = 1'b1;
        res_pass  = pass_w[u];
        res_err   = err_of(u);
        res_fvec  = fvec_w[u];
        res_fseen = fseen_w[u];
      end
      if (k < ncyc) @(negedge clk);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({a_w[0], b_w[0], c_w[0], busy_w[0], done_w[0], pass_w[0], fseen_w[0], fvec_w[0], err0} !== 14'd0)
      $display("FAIL reset_u0: got %b want all zero",
               {a_w[0], b_w[0], c_w[0], busy_w[0], done_w[0], pass_w[0], fseen_w[0], fvec_w[0], err0});
    else n_pass++;
    n_checks++;
    if ({busy_w[1], busy_w[2], err1, err2} !== 8'd0)
      $display("FAIL reset_u1u2: got %b want all zero", {busy_w[1], busy_w[2], err1, err2});
    else n_pass++;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sweep_ok();
    cyc_t e, o;
    int n;
    logic [2:0] fv;
    fault[0] = 0;
    model(0, 4, n, fv);
    push_sweep(1);
    run_sweep(0, 18);
    for (int k = 1; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL sweep_ok cycle%0d: no sample, want %b", k, e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL sweep_ok cycle%0d busy/done/abc: got %b want %b", k, o, e);
        else n_pass++;
      end
    end
    obs_q.delete();
    n_checks++;
    if (!(res_done === 1'b1 && res_pass === 1'b1 && res_err == n && res_fseen === 1'b0 && res_fvec === fv))
      $display("FAIL sweep_ok result: done=%b pass=%b err=%0d seen=%b fvec=%b want 1 1 %0d 0 %b",
               res_done, res_pass, res_err, res_fseen, res_fvec, n, fv);
    else n_pass++;
  endtask

  task automatic test_cout_stuck();
    int n;
    logic [2:0] fv;
    fault[0] = 1;
    model(1, 4, n, fv);
    run_sweep(0, 18);
    obs_q.delete();
    n_checks++;
    if (res_done !== 1'b1) $display("FAIL cout_stuck done: got %b want 1", res_done);
    else n_pass++;
    n_checks++;
    if (res_err !== 4 || res_err !== n) $display("FAIL cout_stuck err_cnt: got %0d want 4", res_err);
    else n_pass++;
    n_checks++;
    if (res_fvec !== 3'b011 || res_fseen !== 1'b1)
      $display("FAIL cout_stuck fail_vec/seen: got %b/%b want 011/1", res_fvec, res_fseen);
    else n_pass++;
    n_checks++;
    if (res_pass !== 1'b0) $display("FAIL cout_stuck pass: got %b want 0", res_pass);
    else n_pass++;
    n_checks++;
    if (pass_w[0] !== 1'b0 || err0 !== 4'd4)
      $display("FAIL cout_stuck hold: got pass=%b err=%0d want 0 4", pass_w[0], err0);
    else n_pass++;
    fault[0] = 0;
  endtask

  task automatic test_saturate();
    int n;
    logic [2:0] fv;
    fault[1] = 2;
    model(2, 2, n, fv);
    run_sweep(1, 18);
    obs_q.delete();
    n_checks++;
    if (res_done !== 1'b1 || res_err !== 3 || res_err !== n)
      $display("FAIL saturate err_cnt: done=%b got %0d want 3", res_done, res_err);
    else n_pass++;
    n_checks++;
    if (res_fvec !== 3'b000 || res_fseen !== 1'b1 || res_pass !== 1'b0)
      $display("FAIL saturate vec/seen/pass: got %b/%b/%b want 000/1/0", res_fvec, res_fseen, res_pass);
    else n_pass++;
    fault[1] = 0;
  endtask

  task automatic test_settle0();
    cyc_t e, o;
    push_sweep(0);
    run_sweep(2, 10);
    for (int k = 1; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL settle0 cycle%0d: no sample, want %b", k, e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL settle0 cycle%0d busy/done/abc: got %b want %b", k, o, e);
        else n_pass++;
      end
    end
    obs_q.delete();
    n_checks++;
    if (res_done !== 1'b1 || res_pass !== 1'b1 || res_err !== 0)
      $display("FAIL settle0 result: done=%b pass=%b err=%0d want 1 1 0", res_done, res_pass, res_err);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    fault[0] = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({busy_w[0], a_w[0], b_w[0], c_w[0]} !== 4'b1010)
      $display("FAIL mid_reset pre: got busy/abc %b want 1010", {busy_w[0], a_w[0], b_w[0], c_w[0]});
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({a_w[0], b_w[0], c_w[0], busy_w[0], done_w[0], pass_w[0], fseen_w[0], fvec_w[0], err0} !== 14'd0)
      $display("FAIL mid_reset post: got %b want all zero",
               {a_w[0], b_w[0], c_w[0], busy_w[0], done_w[0], pass_w[0], fseen_w[0], fvec_w[0], err0});
    else n_pass++;
    repeat (20) @(negedge clk);
    run_sweep(0, 18);
    obs_q.delete();
    n_checks++;
    if (res_done !== 1'b1 || res_pass !== 1'b1 || res_err !== 0)
      $display("FAIL mid_reset resweep: done=%b pass=%b err=%0d want 1 1 0", res_done, res_pass, res_err);
    else n_pass++;
  endtask

`ifdef FA_BIST_CONT_EN
  task automatic test_cont();
    cyc_t e, o;
    int dn;
    dn = 0;
    fault[0] = 1;
    for (int k = 1; k <= 33; k++) begin
      e.done = (k == 17) || (k == 33);
      e.busy = !e.done;
      e.abc  = (k <= 16) ? 3'((k - 1) / 2) : (e.done ? 3'd0 : 3'((k - 17) / 2));
      exp_q.push_back(e);
    end
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      o.busy = busy_w[0];
      o.done = done_w[0];
      o.abc  = {a_w[0], b_w[0], c_w[0]};
      obs_q.push_back(o);
      if (done_w[0]) begin
        dn++;
        n_checks++;
        if (err0 !== ((dn == 1) ? 4'd4 : 4'd8))
          $display("FAIL cont err_cnt done#%0d: got %0d want %0d", dn, err0, (dn == 1) ? 4 : 8);
        else n_pass++;
        n_checks++;
        if (fvec_w[0] !== 3'b011 || pass_w[0] !== 1'b0)
          $display("FAIL cont fail_vec/pass done#%0d: got %b/%b want 011/0", dn, fvec_w[0], pass_w[0]);
        else n_pass++;
      end
    end
    start = 1'b0;
    for (int k = 1; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL cont cycle%0d: no sample, want %b", k, e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL cont cycle%0d busy/done/abc: got %b want %b", k, o, e);
        else n_pass++;
      end
    end
    obs_q.delete();
    n_checks++;
    if (dn != 2) $display("FAIL cont done count: got %0d want 2", dn);
    else n_pass++;
    repeat (40) @(negedge clk);
    fault[0] = 0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_sweep_ok();
    test_cout_stuck();
    test_saturate();
    test_settle0();
    test_mid_reset();
`ifdef FA_BIST_CONT_EN
    test_cont();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fa_bist.md
# fa_bist

Built-in self-test controller for the one-bit full adder. Drives the adder's `a`, `b`, `c` inputs through all eight combinations. Samples `sum` and `cout` after a programmable settle time and compares them against a golden model. Reports pass/fail, an error count and the first failing vector. It is the checking end of the full-adder interface: it consumes the adder's outputs and produces its stimulus, so the adder can be tested in silicon without a testbench.

## Interface
- `SETTLE_CYCLES`, default 1: cycles each vector is held before sampling; legal range 0..15.
- `ERR_W`, default 4: width of the error counter.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level; sampled in IDLE to begin a sweep.
- `a`, `b`, `c`  out  1 each  registered stimulus to the adder.
- `sum`, `cout`  in  1 each  adder response.
- `busy`  out  1  high from the first drive cycle through the last check cycle.
- `done`  out  1  one-cycle pulse at end of sweep.
- `pass`  out  1  1 when the last completed sweep had zero errors; held until the next sweep starts.
- `err_cnt`  out  `ERR_W`  mismatching vectors; saturates at 2^ERR_W-1.
- `fail_vec`  out  3  {a,b,c} of the first mismatch in the sweep; 0 if there is none.
- `fail_seen`  out  1  a mismatch occurred this sweep.

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE, `start`=1: vector index `v`←0; `err_cnt`, `fail_vec`, `fail_seen` and `pass` clear to 0. Go to SETTLE, or to CHECK if `SETTLE_CYCLES`=0.
- Vector drive: {a,b,c} = `v`, with `a` as the MSB. Sweep order is 000,001,…,111.
- SETTLE: holds for `SETTLE_CYCLES` cycles (down-counter), then goes to CHECK.
- CHECK: one cycle. Compares against the golden model, exp_sum = a^b^c and exp_cout = ab|ac|bc.
- On a mismatch in CHECK:
  - `err_cnt` increments, saturating.
  - If `fail_seen`=0: `fail_vec`←`v` and `fail_seen`←1.
- After CHECK: if `v`=7 go to DONE; otherwise `v`←`v`+1 and go to SETTLE (or CHECK if `SETTLE_CYCLES`=0).
- DONE: one cycle. `done`=1 and `pass`←(mismatch count for the sweep = 0, including the final CHECK). Then go to IDLE.
- `start` is ignored outside IDLE. A `start` still high in IDLE after DONE begins a new sweep, unless the continuous-mode macro is defined (see Configuration).
- In IDLE, `a`,`b`,`c` hold 0.

## Timing
- Reset values: `a`=`b`=`c`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_vec`=0, `fail_seen`=0, state IDLE.
- `rst` wins over every other event. Reset mid-sweep returns to IDLE on the next edge with all outputs at reset values.
- The stimulus for vector `v` appears on the first cycle of that vector. The DUT is assumed combinational, and its response is compared in the same CHECK cycle.
- Each vector occupies `SETTLE_CYCLES`+1 cycles.
- Sweep latency:
  - `start` seen at edge N → vector 0 is driven from edge N+1.
  - `done` is high on cycle N+1+8·(`SETTLE_CYCLES`+1).
- `busy` falls in the DONE cycle.
- `pass`, `err_cnt` and `fail_vec` are valid from the DONE cycle until the next sweep's start edge.
- A mismatch on the final CHECK (v=7) is counted before `pass` is evaluated.
- Saturation: at `err_cnt`=2^ERR_W-1, further mismatches leave it unchanged.

## Configuration
- `FA_BIST_CONT_EN`, defined (continuous mode):
  - From DONE, if `start`=1, go directly to the first vector. `err_cnt` keeps accumulating across sweeps, and `fail_vec`/`fail_seen` retain the first failure.
  - `done` pulses once per sweep, and `pass` reflects the cumulative count.
  - `start`=0 at DONE returns to IDLE.
- `FA_BIST_CONT_EN` undefined: single-sweep behaviour exactly as described above, with counters cleared on each start.

## Structure
- Package `fa_bist_pkg` holds:
  - the state enum (IDLE, SETTLE, CHECK, DONE);
  - the constants NUM_VEC=8 and LAST_VEC=3'd7;
  - a golden function returning {cout,sum} from {a,b,c}.
- One sub-module, `fa_golden`: a combinational reference adder producing the expected {cout,sum}. It is instantiated once in `fa_bist`.
- The `full_adder` DUT is instantiated beside `fa_bist` at the test top level, not inside it.

## Test plan
- Correct adder, `SETTLE_CYCLES`=1, `start` pulsed at cycle 0: `done` at cycle 17, `pass`=1, `err_cnt`=0, `fail_seen`=0, and `a`,`b`,`c` walk 000→111.
- DUT with `cout` stuck at 0: vectors 011, 101, 110 and 111 fail. Expect `err_cnt`=4, `fail_vec`=3'b011, `pass`=0.
- DUT with `sum` inverted, `ERR_W`=2: 8 mismatches, `err_cnt` saturates at 3, `fail_vec`=000.
- `rst` asserted at cycle 6 mid-sweep: the next cycle shows the IDLE state and all outputs 0. A fresh `start` then completes a normal sweep.
- `SETTLE_CYCLES`=0: `busy` high for 8 cycles, `done` on cycle 9, one vector per cycle.
- `FA_BIST_CONT_EN` with `start` held high and a `cout`-stuck-0 DUT: `done` pulses at cycles 17 and 33, `err_cnt` is 4 then 8, and `fail_vec`=011 is retained.
